// File: rtl/sdu_uart_rx.sv
// sdu_uart_rx: 16x oversampled 8N1 receiver feeding a valid/ready byte buffer.
// Define SDU_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module sdu_uart_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output logic [7:0] dout,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int DIV = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
    localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

    state_t        state;
    logic [1:0]    sync;
    logic [1:0]    live;
    logic [CW-1:0] cnt;
    logic [3:0]    s;
    logic [2:0]    idx;
    logic [1:0]    smp;
    logic [7:0]    sh;
    logic          armed;
    logic          rxs, tick, mid, maj, push, pop;

    assign rxs  = sync[1];
    assign tick = cnt == CW'(DIV - 1);
    assign mid  = tick && s == 4'd8;
    assign maj  = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
    assign push = state == STOP && mid && maj;
    assign pop  = valid && ready;
    assign busy = state != IDLE;

    // live gates arming until the synchronizer holds real line samples, not its reset value
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync <= 2'b11;
            live <= 2'b00;
        end else begin
            sync <= {sync[0], rxd};
            live <= {live[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            s         <= '0;
            idx       <= '0;
            smp       <= '0;
            sh        <= '0;
            armed     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cnt       <= tick ? '0 : cnt + 1'b1;
            s         <= tick ? s + 1'b1 : s;
            frame_err <= 1'b0;
            if (tick && (s == 4'd6 || s == 4'd7))
                smp <= {smp[0], rxs};
            case (state)
                IDLE: begin
                    armed <= armed | (rxs & live[1]);
                    if (armed && !rxs) begin
                        cnt   <= '0;
                        s     <= '0;
                        idx   <= '0;
                        armed <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (mid && maj)
                        state <= IDLE;
                    else if (tick && s == 4'd15)
                        state <= DATA;
                end
                DATA: begin
                    if (mid)
                        sh <= {maj, sh[7:1]};
                    if (tick && s == 4'd15) begin
                        idx <= idx + 1'b1;
                        if (idx == 3'd7)
                            state <= STOP;
                    end
                end
                // good stop returns to IDLE at the decision so back-to-back starts are caught
                STOP: begin
                    if (mid) begin
                        frame_err <= !maj;
                        state     <= maj ? IDLE : WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (rxs)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SDU_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wp, rp;
    logic        full, wr;

    assign full  = (wp - rp) == (AW + 1)'(FIFO_DEPTH);
    assign wr    = push && (!full || pop);
    assign valid = wp != rp;
    assign dout  = valid ? mem[rp[AW-1:0]] : 8'h00;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp      <= '0;
            rp      <= '0;
            overrun <= 1'b0;
        end else begin
            wp      <= wr ? wp + 1'b1 : wp;
            rp      <= pop ? rp + 1'b1 : rp;
            overrun <= push && full && !pop;
        end
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[wp[AW-1:0]] <= sh;
    end
`else
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout    <= 8'h00;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (push && (!valid || pop))
                dout <= sh;
            valid   <= push || (valid && !pop);
            overrun <= push && valid && !pop;
        end
    end
`endif

endmodule

// File: tb/tb_sdu_uart_rx.sv
// tb_sdu_uart_rx: drives 8N1 frames (directed and $urandom) and checks against a byte-queue
// model of the receive buffer; define SDU_RX_FIFO_EN to exercise the FIFO build.
`timescale 1ns/1ps
module tb_sdu_uart_rx;
    localparam int BIT = 64;
`ifdef SDU_RX_FIFO_EN
    localparam int CAP = 8;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rxd = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] dout;
    logic       valid, frame_err, overrun, busy;

    int checks = 0, errors = 0;
    int fe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_ov = 0, pops = 0;
    logic [7:0] exp_q[$];

    sdu_uart_rx #(.CLK_FREQ(6_400_000), .BAUD(100_000), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rstn(rstn), .rxd(rxd), .dout(dout), .valid(valid), .ready(ready),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: a frame with a good stop enters the buffer unless it already holds CAP bytes.
    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (!stop) exp_fe++;
        else if (exp_q.size() >= CAP) exp_ov++;
        else exp_q.push_back(b);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int stop_len);
        rxd = 1'b0;
        cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            cyc(BIT);
        end
        rxd = stop;
        cyc(stop_len);
    endtask

    task automatic timed_frame(input logic [7:0] b, input string tag);
        int n;
        n = 0;
        model_frame(b, 1'b1);
        fork
            send_byte(b, 1'b1, BIT);
            begin
                while (!valid && n < 700) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
            end
        join
        check(tag, (n >= 614 && n <= 616) ? 32'd615 : n, 32'd615);
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (valid && ready) begin
                pops++;
                check("pop_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("pop_data", dout, exp_q.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, f0, o0;
        logic [7:0] b;
        @(posedge clk);
        #1;
        cyc(3);
        check("rst_dout", dout, 0);
        check("rst_valid", valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        rstn = 1'b1;
        cyc(5);

        ready = 1'b1;
        timed_frame(8'h55, "lat_55");
        cyc(10);
        timed_frame(8'hA3, "lat_A3");
        cyc(10);
        check("rx_2_popped", pops, 2);
        check("rx_fe_none", fe_cnt, 0);

        p0 = pops;
        rxd = 1'b0;
        cyc(10);
        check("glitch_busy", busy, 1);
        cyc(10);
        rxd = 1'b1;
        cyc(100);
        check("glitch_valid", valid, 0);
        check("glitch_idle", busy, 0);
        check("glitch_nopop", pops, p0);

        f0 = fe_cnt;
        model_frame(8'h7E, 1'b0);
        send_byte(8'h7E, 1'b0, BIT);
        cyc(700);
        check("fe_pulse", fe_cnt - f0, 1);
        check("fe_valid", valid, 0);
        check("fe_wait_hi", busy, 1);
        rxd = 1'b1;
        cyc(10);
        check("fe_idle", busy, 0);

        ready = 1'b0;
        o0 = ov_cnt;
`ifdef SDU_RX_FIFO_EN
        for (int i = 0; i < 9; i++) begin
            model_frame(i[7:0], 1'b1);
            send_byte(i[7:0], 1'b1, BIT);
        end
        cyc(10);
        check("ovr_pulse", ov_cnt - o0, 1);
        check("ovr_head", dout, 8'h00);
`else
        model_frame(8'h11, 1'b1);
        send_byte(8'h11, 1'b1, BIT);
        model_frame(8'h22, 1'b1);
        send_byte(8'h22, 1'b1, BIT);
        cyc(10);
        check("ovr_pulse", ov_cnt - o0, 1);
        check("ovr_head", dout, 8'h11);
`endif
        check("ovr_valid", valid, 1);
        ready = 1'b1;
        cyc(20);
        check("ovr_drained", exp_q.size(), 0);

        for (int k = 0; k < 10; k++) begin
            logic stop;
            b = 8'($urandom);
            stop = $urandom_range(0, 5) != 0;
            model_frame(b, stop);
            send_byte(b, stop, stop ? $urandom_range(42, BIT) : BIT);
            rxd = 1'b1;
            cyc(stop ? $urandom_range(0, 30) : $urandom_range(4, 30));
        end
        cyc(20);
        check("rand_drained", exp_q.size(), 0);
        check("rand_fe_total", fe_cnt, exp_fe);
        check("rand_ov_total", ov_cnt, exp_ov);

        ready = 1'b0;
        b = 8'($urandom);
        model_frame(b, 1'b1);
        send_byte(b, 1'b1, BIT);
        cyc(5);
        check("pre_rst_valid", valid, 1);
        rxd = 1'b0;
        cyc(BIT);
        b = 8'($urandom);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            cyc(BIT);
        end
        rxd = b[4];
        cyc(BIT / 2);
        rstn = 1'b0;
        rxd = 1'b1;
        #1;
        check("mid_rst_dout", dout, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_flags", {frame_err, overrun}, 0);
        exp_q.delete();
        cyc(5);
        rstn = 1'b1;
        cyc(5);
        check("post_rst_valid", valid, 0);
        check("post_rst_busy", busy, 0);
        ready = 1'b1;
        p0 = pops;
        timed_frame(8'hC5, "lat_C5");
        cyc(10);
        check("post_rst_rx", pops - p0, 1);
        check("final_fe", fe_cnt, exp_fe);
        check("final_ov", ov_cnt, exp_ov);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
